// File: rtl/color_classifier.sv
//------------------------------------------------------------------------------
// color_classifier
// Per-frame dominant-colour vote over a 12-bit RGB444 pixel stream.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module color_classifier #(
    parameter logic [3:0] CHAN_MIN  = 4'd8,
    parameter logic [3:0] MARGIN    = 4'd3,
    parameter int         MIN_COUNT = 1024,
    parameter int         CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_in,
    input  logic        in_ready,
    input  logic        frame_start,
    input  logic        frame_end,
    output logic [2:0]  parcel_color,
    output logic        color_valid
);

    localparam logic [1:0]       S_IDLE    = 2'd0;
    localparam logic [1:0]       S_ACCUM   = 2'd1;
    localparam logic [1:0]       S_DECIDE  = 2'd2;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [31:0]      C_MIN     = 32'(MIN_COUNT);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [2:0][CNT_W-1:0] r_cnt;
    logic [4:0]            w_red, w_grn, w_blu, w_margin, w_min;
    logic [2:0]            w_match;
    logic                  w_clear;
    logic                  w_count;
    logic                  w_decide;
    logic [2:0]            w_min_ok;
    logic [2:0]            w_result;

    // Five-bit sums: a channel plus MARGIN above 15 can never be met.
    assign w_red    = {1'b0, pixel_in[11:8]};
    assign w_grn    = {1'b0, pixel_in[7:4]};
    assign w_blu    = {1'b0, pixel_in[3:0]};
    assign w_margin = {1'b0, MARGIN};
    assign w_min    = {1'b0, CHAN_MIN};

    always_comb begin
        w_match    = 3'b000;
        w_match[0] = (w_red >= w_min) && (w_red >= w_grn + w_margin) && (w_red >= w_blu + w_margin);
        w_match[1] = !w_match[0] &&
                     (w_grn >= w_min) && (w_grn >= w_red + w_margin) && (w_grn >= w_blu + w_margin);
        w_match[2] = !w_match[0] && !w_match[1] &&
                     (w_blu >= w_min) && (w_blu >= w_red + w_margin) && (w_blu >= w_grn + w_margin);
    end

    assign w_clear = ((r_state == S_IDLE) && frame_start) ||
                     ((r_state == S_ACCUM) && frame_start && !frame_end);
    assign w_count = (r_state == S_ACCUM) && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_start) w_state_next = S_ACCUM;
            S_ACCUM:  if (frame_end)   w_state_next = S_DECIDE;
            S_DECIDE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // A restart cycle clears the counters but still counts its own pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_clear) begin
                    r_cnt[i] <= (w_count && w_match[i]) ? CNT_W'(1) : '0;
                end else if (w_count && w_match[i] && (r_cnt[i] != C_CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_decide = (r_state == S_DECIDE);
        w_result = 3'd0;
        for (int i = 0; i < 3; i++) begin
            w_min_ok[i] = (32'(r_cnt[i]) >= C_MIN);
        end
        // Strict comparisons make any tie for the maximum fall through to 0.
        if (w_min_ok[0] && (r_cnt[0] > r_cnt[1]) && (r_cnt[0] > r_cnt[2])) begin
            w_result = 3'd1;
        end else if (w_min_ok[1] && (r_cnt[1] > r_cnt[0]) && (r_cnt[1] > r_cnt[2])) begin
            w_result = 3'd2;
        end else if (w_min_ok[2] && (r_cnt[2] > r_cnt[0]) && (r_cnt[2] > r_cnt[1])) begin
            w_result = 3'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parcel_color <= 3'd0;
            color_valid  <= 1'b0;
        end else begin
            color_valid <= w_decide;
            if (w_decide) begin
                parcel_color <= w_result;
            end
        end
    end

endmodule

`default_nettype wire
